// File: rtl/traffic_ctrl_multi.sv
// traffic_ctrl_multi
//   Round-robin traffic-light controller for NDIR approach directions.
//   One direction at a time owns the right of way and cycles through
//   GREEN -> YELLOW -> (ALL_RED) -> GREEN. Green ends only when another
//   direction is waiting and either the owner has gone quiet or the green
//   timeout has expired. Once green ends, the next owner is fixed.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset (dir 0 GREEN while held)
//   car      in   [NDIR-1:0] per-direction vehicle request, level sensitive
//   light    out  [3*NDIR-1:0] per-direction lamp, slice [3i+2:3i] one-hot:
//                 RED=100, YELLOW=010, GREEN=001 (registered)
//   cur_dir  out  [clog2(NDIR)-1:0] direction owning green/yellow (registered)
//   phase    out  [1:0] GREEN=00, YELLOW=01, ALL_RED=10 (registered)
module traffic_ctrl_multi #(
    parameter int NDIR       = 4,
    parameter int MIN_GREEN  = 2,
    parameter int MAX_GREEN  = 8,
    parameter int YELLOW_CYC = 1,
    parameter int ALLRED_CYC = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NDIR-1:0]         car,
    output logic [3*NDIR-1:0]       light,
    output logic [$clog2(NDIR)-1:0] cur_dir,
    output logic [1:0]              phase
);

    localparam int DW = $clog2(NDIR);

    // Counter only has to reach the largest duration it is compared against.
    localparam int CNT_TOP_A = (MIN_GREEN > MAX_GREEN) ? MIN_GREEN : MAX_GREEN;
    localparam int CNT_TOP_B = (YELLOW_CYC > ALLRED_CYC) ? YELLOW_CYC : ALLRED_CYC;
    localparam int CNT_TOP   = (CNT_TOP_A > CNT_TOP_B) ? CNT_TOP_A : CNT_TOP_B;
    localparam int CW        = $clog2(CNT_TOP + 1);

    localparam logic [CW-1:0] CNT_SAT  = '1;
    localparam logic [CW-1:0] MIN_LAST = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] MAX_LAST = CW'((MAX_GREEN > 0) ? MAX_GREEN - 1 : 0);
    localparam logic [CW-1:0] Y_LAST   = CW'(YELLOW_CYC - 1);
    localparam logic [CW-1:0] AR_LAST  = CW'((ALLRED_CYC > 0) ? ALLRED_CYC - 1 : 0);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        PH_GREEN   = 2'b00,
        PH_YELLOW  = 2'b01,
        PH_ALL_RED = 2'b10
    } phase_e;

    // Lamp vector for a given phase and owning direction.
    function automatic logic [3*NDIR-1:0] lamp(input phase_e ph, input logic [DW-1:0] dir);
        logic [3*NDIR-1:0] v;
        v = '0;
        for (int unsigned d = 0; d < NDIR; d++) begin
            if (ph != PH_ALL_RED && DW'(d) == dir) begin
                v[3*d +: 3] = (ph == PH_GREEN) ? LAMP_GREEN : LAMP_YELLOW;
            end else begin
                v[3*d +: 3] = LAMP_RED;
            end
        end
        return v;
    endfunction

    phase_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]       cur_dir_q, cur_dir_d;
    logic [DW-1:0]       next_dir_q, next_dir_d;
    logic [3*NDIR-1:0]   light_q, light_d;

    logic [NDIR-1:0]     own_mask;
    logic                own_req;
    logic                other_req;
    logic [DW-1:0]       rr_pick;
    logic                rr_found;
    logic [DW-1:0]       rr_idx;

    // Request decode and round-robin search starting just after the owner.
    always_comb begin
        own_mask  = NDIR'(1) << cur_dir_q;
        own_req   = |(car & own_mask);
        other_req = |(car & ~own_mask);
        rr_pick   = cur_dir_q;
        rr_found  = 1'b0;
        rr_idx    = '0;
        for (int unsigned k = 1; k < NDIR; k++) begin
            rr_idx = DW'((32'(cur_dir_q) + k) % NDIR);
            if (!rr_found && car[rr_idx]) begin
                rr_pick  = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    // Next-state logic. cnt clears on every state entry and saturates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        cur_dir_d  = cur_dir_q;
        next_dir_d = next_dir_q;

        unique case (state_q)
            PH_GREEN: begin
                if (cnt_q >= MIN_LAST && other_req &&
                    (!own_req || (MAX_GREEN != 0 && cnt_q >= MAX_LAST))) begin
                    state_d    = PH_YELLOW;
                    cnt_d      = '0;
                    next_dir_d = rr_pick;
                end
            end
            PH_YELLOW: begin
                if (cnt_q >= Y_LAST) begin
                    cnt_d = '0;
                    if (ALLRED_CYC > 0) begin
                        state_d = PH_ALL_RED;
                    end else begin
                        state_d   = PH_GREEN;
                        cur_dir_d = next_dir_q;
                    end
                end
            end
            PH_ALL_RED: begin
                if (cnt_q >= AR_LAST) begin
                    state_d   = PH_GREEN;
                    cnt_d     = '0;
                    cur_dir_d = next_dir_q;
                end
            end
            default: begin
                state_d = PH_GREEN;
                cnt_d   = '0;
            end
        endcase

        // Lamps are registered from the next state so they always match
        // phase/cur_dir in the same cycle.
        light_d = lamp(state_d, cur_dir_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PH_GREEN;
            cnt_q      <= '0;
            cur_dir_q  <= '0;
            next_dir_q <= '0;
            light_q    <= lamp(PH_GREEN, '0);
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_dir_q  <= cur_dir_d;
            next_dir_q <= next_dir_d;
            light_q    <= light_d;
        end
    end

    assign light   = light_q;
    assign cur_dir = cur_dir_q;
    assign phase   = state_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// tb_traffic_ctrl_multi
//   Two controller instances: A with default parameters (4 directions) and
//   B with 2 directions, 3-cycle yellow and no all-red. A reference model
//   steps once per rising edge and queues the expected outputs; a monitor
//   on the falling edge pops and compares, and also checks lamp legality.
module tb_traffic_ctrl_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  car_a = '0;
    logic [1:0]  car_b = 2'b01;
    logic [11:0] light_a;
    logic [1:0]  cur_dir_a;
    logic [1:0]  phase_a;
    logic [5:0]  light_b;
    logic [0:0]  cur_dir_b;
    logic [1:0]  phase_b;

    int n_tests = 0;
    int n_fail  = 0;

    traffic_ctrl_multi #(
        .NDIR(4), .MIN_GREEN(2), .MAX_GREEN(8), .YELLOW_CYC(1), .ALLRED_CYC(1)
    ) u_a (
        .clk(clk), .rst(rst), .car(car_a),
        .light(light_a), .cur_dir(cur_dir_a), .phase(phase_a)
    );

    traffic_ctrl_multi #(
        .NDIR(2), .MIN_GREEN(2), .MAX_GREEN(8), .YELLOW_CYC(3), .ALLRED_CYC(0)
    ) u_b (
        .clk(clk), .rst(rst), .car(car_b),
        .light(light_b), .cur_dir(cur_dir_b), .phase(phase_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // ph: 0 green, 1 yellow, 2 all-red. held = green cycles completed,
    // left = cycles remaining in yellow / all-red.
    typedef struct {
        int ph;
        int owner;
        int nxt;
        int held;
        int left;
    } mstate_t;

    typedef struct {
        logic [11:0] la;
        int          ca;
        int          pa;
        logic [5:0]  lb;
        int          cb;
        int          pb;
    } exp_t;

    function automatic mstate_t m_step(mstate_t s, int carv, bit r,
                                       int nd, int mn, int mx, int y, int ar);
        mstate_t n;
        int others;
        bit leave;
        bit found;
        n = s;
        if (r) begin
            n.ph = 0; n.owner = 0; n.nxt = 0; n.held = 0; n.left = 0;
            return n;
        end
        case (s.ph)
            0: begin
                n.held = s.held + 1;
                others = carv & ~(1 << s.owner);
                leave  = (others != 0) && (n.held >= mn) &&
                         ((((carv >> s.owner) & 1) == 0) || (mx != 0 && n.held >= mx));
                if (leave) begin
                    found = 0;
                    for (int k = 1; k < nd; k++) begin
                        if (!found && (((carv >> ((s.owner + k) % nd)) & 1) != 0)) begin
                            n.nxt = (s.owner + k) % nd;
                            found = 1;
                        end
                    end
                    n.ph   = 1;
                    n.left = y;
                end
            end
            1: begin
                n.left = s.left - 1;
                if (n.left == 0) begin
                    if (ar > 0) begin
                        n.ph = 2; n.left = ar;
                    end else begin
                        n.ph = 0; n.owner = s.nxt; n.held = 0;
                    end
                end
            end
            default: begin
                n.left = s.left - 1;
                if (n.left == 0) begin
                    n.ph = 0; n.owner = s.nxt; n.held = 0;
                end
            end
        endcase
        return n;
    endfunction

    function automatic logic [23:0] m_light(mstate_t s, int nd);
        logic [23:0] v;
        v = '0;
        for (int d = 0; d < nd; d++) begin
            if (s.ph != 2 && d == s.owner)
                v[3*d +: 3] = (s.ph == 0) ? 3'b001 : 3'b010;
            else
                v[3*d +: 3] = 3'b100;
        end
        return v;
    endfunction

    mstate_t ma = '{0, 0, 0, 0, 0};
    mstate_t mb = '{0, 0, 0, 0, 0};
    exp_t    q[$];

    always @(posedge clk) begin
        exp_t        e;
        logic [23:0] lv;
        ma = m_step(ma, int'(car_a), rst, 4, 2, 8, 1, 1);
        mb = m_step(mb, int'(car_b), rst, 2, 2, 8, 3, 0);
        lv   = m_light(ma, 4);
        e.la = lv[11:0];
        e.ca = ma.owner;
        e.pa = ma.ph;
        lv   = m_light(mb, 2);
        e.lb = lv[5:0];
        e.cb = mb.owner;
        e.pb = mb.ph;
        q.push_back(e);
    end

    // ---------------- monitor ----------------
    function automatic int lamp_viol(logic [23:0] cur, logic [23:0] prv, bit pok, int nd);
        int v, nr;
        logic [2:0] sl, ps;
        v = 0; nr = 0;
        for (int d = 0; d < nd; d++) begin
            sl = cur[3*d +: 3];
            ps = prv[3*d +: 3];
            if (!(sl == 3'b100 || sl == 3'b010 || sl == 3'b001)) v++;
            if (sl != 3'b100) nr++;
            if (pok && ps == 3'b001 && sl == 3'b100) v++;
        end
        if (nr > 1) v++;
        return v;
    endfunction

    logic [23:0] prev_a = '0;
    logic [23:0] prev_b = '0;
    bit          prev_ok = 0;
    int          ylen_b = 0;

    always @(negedge clk) begin
        exp_t e;
        if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL queue_empty: got 0 entries expected >=1 (t=%0t)", $time);
        end else begin
            e = q.pop_front();
            chk("A.light",   32'(light_a),   32'(e.la));
            chk("A.cur_dir", 32'(cur_dir_a), e.ca);
            chk("A.phase",   32'(phase_a),   e.pa);
            chk("B.light",   32'(light_b),   32'(e.lb));
            chk("B.cur_dir", 32'(cur_dir_b), e.cb);
            chk("B.phase",   32'(phase_b),   e.pb);
        end
        if (rst) begin
            prev_ok = 0;
            ylen_b  = 0;
        end else begin
            chk("A.lamp_rules", lamp_viol(24'(light_a), prev_a, prev_ok, 4), 0);
            chk("B.lamp_rules", lamp_viol(24'(light_b), prev_b, prev_ok, 2), 0);
            if (phase_b == 2'b01) begin
                ylen_b++;
            end else if (ylen_b > 0) begin
                chk("B.yellow_len", ylen_b, 3);
                ylen_b = 0;
            end
            prev_ok = 1;
        end
        prev_a = 24'(light_a);
        prev_b = 24'(light_b);
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [11:0] seq31 [5];
    bit          found_ar;
    bit          bsel;

    initial begin
        seq31[0] = 12'b100_100_100_001;
        seq31[1] = 12'b100_100_100_001;
        seq31[2] = 12'b100_100_100_010;
        seq31[3] = 12'b100_100_100_100;
        seq31[4] = 12'b100_100_001_100;

        rst = 1'b1; car_a = 4'b0001; car_b = 2'b01;
        repeat (3) @(posedge clk);
        #1;

        // Owner alone requesting keeps green forever.
        release_rst();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold.phase", 32'(phase_a), 0);
            chk("hold.light", 32'(light_a), 32'(12'b100_100_100_001));
        end

        // Single request from dir1.
        do_reset();
        car_a = 4'b0010;
        car_b = 2'b10;
        release_rst();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("dir1.light", 32'(light_a), 32'(seq31[i]));
        end
        chk("dir1.cur_dir", 32'(cur_dir_a), 1);

        // Timeout with round-robin skipping dir2.
        do_reset();
        car_a = 4'b1011;
        car_b = 2'b11;
        release_rst();
        for (int i = 0; i <= 30; i++) begin
            @(negedge clk);
            if (i == 7)  chk("rr.last_green", 32'(phase_a), 0);
            if (i == 8)  chk("rr.timeout_yel", 32'(phase_a), 1);
            if (i == 10) chk("rr.dir1", 32'(cur_dir_a), 1);
            if (i == 20) chk("rr.dir3", 32'(cur_dir_a), 3);
            if (i == 30) chk("rr.dir0", 32'(cur_dir_a), 0);
        end

        // next_dir latched at the green->yellow edge.
        do_reset();
        car_a = 4'b0100;
        car_b = 2'b01;
        release_rst();
        repeat (2) @(posedge clk);
        #1 car_a = 4'b1000;
        repeat (3) @(negedge clk);
        chk("latch.dir2", 32'(cur_dir_a), 2);
        chk("latch.dir2_phase", 32'(phase_a), 0);
        repeat (4) @(negedge clk);
        chk("latch.dir3", 32'(cur_dir_a), 3);
        chk("latch.dir3_phase", 32'(phase_a), 0);

        // Asynchronous reset during ALL_RED.
        #1 car_a = 4'b1111;
        found_ar = 0;
        for (int i = 0; i < 100 && !found_ar; i++) begin
            @(negedge clk);
            if (phase_a == 2'b10) found_ar = 1;
        end
        chk("ar.reached", 32'(found_ar), 1);
        #1 rst = 1'b1;
        #1;
        chk("ar.rst_light", 32'(light_a), 32'(12'b100_100_100_001));
        chk("ar.rst_phase", 32'(phase_a), 0);
        chk("ar.rst_cur",   32'(cur_dir_a), 0);
        chk("ar.rst_light_b", 32'(light_b), 32'(6'b100_001));
        release_rst();

        // Random traffic; B alternates between its two directions.
        bsel = 0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) car_a = 4'($urandom);
            if ($urandom_range(0, 5) == 0) bsel = ~bsel;
            case ($urandom_range(0, 9))
                0:       car_b = 2'b11;
                1:       car_b = 2'b00;
                default: car_b = bsel ? 2'b10 : 2'b01;
            endcase
        end

        repeat (2) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_multi.md
TRAFFIC_CTRL_MULTI -- requirements
Module: traffic_ctrl_multi

Interface
REQ-001 Parameter NDIR, default 4, number of approach directions; legal range 2..8.
REQ-002 Parameter MIN_GREEN, default 2, minimum green cycles; legal range >= 1.
REQ-003 Parameter MAX_GREEN, default 8, green timeout in cycles; 0 disables the timeout, otherwise >= MIN_GREEN.
REQ-004 Parameter YELLOW_CYC, default 1, yellow duration in cycles; legal range >= 1.
REQ-005 Parameter ALLRED_CYC, default 1, all-red clearance in cycles; 0 skips the ALL_RED state.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset; asynchronous, active-high.
REQ-008 car  input  NDIR  per-direction vehicle request; bit i is direction i, level-sensitive, sampled every clk.
REQ-009 light  output  3*NDIR  per-direction lamp, slice [3i+2:3i] one-hot, RED=100, YELLOW=010, GREEN=001; registered.
REQ-010 cur_dir  output  clog2(NDIR)  direction currently owning green/yellow; registered.
REQ-011 phase  output  2  FSM state, GREEN=00, YELLOW=01, ALL_RED=10; 11 is never driven.

Function
REQ-012 FSM states SHALL be GREEN, YELLOW and ALL_RED, with a phase counter cnt that clears to 0 on every state entry and increments by 1 each cycle in the state, saturating (never wrapping).
REQ-013 In GREEN, light[cur_dir] SHALL be GREEN and all other slices RED.
REQ-014 In YELLOW, light[cur_dir] SHALL be YELLOW and all other slices RED.
REQ-015 In ALL_RED, every slice SHALL be RED.
REQ-016 other_req SHALL equal 1 when any car bit other than car[cur_dir] is 1.
REQ-017 GREEN SHALL go to YELLOW on the next edge when cnt >= MIN_GREEN-1 and other_req=1 and either (a) car[cur_dir]=0, or (b) MAX_GREEN!=0 and cnt >= MAX_GREEN-1.
REQ-018 When no GREEN->YELLOW condition holds, GREEN SHALL persist indefinitely, including when car is all zeros.
REQ-019 At the GREEN->YELLOW edge, next_dir SHALL be latched as the first requesting direction found searching cur_dir+1, cur_dir+2, ... modulo NDIR (round-robin); car changes after that edge SHALL NOT alter next_dir.
REQ-020 YELLOW SHALL last exactly YELLOW_CYC cycles.
REQ-021 On leaving YELLOW, the FSM SHALL go to ALL_RED if ALLRED_CYC > 0, otherwise directly to GREEN.
REQ-022 ALL_RED SHALL last exactly ALLRED_CYC cycles, then go to GREEN.
REQ-023 On every entry to GREEN, cur_dir SHALL load next_dir.
REQ-024 The controller SHALL never have two slices non-RED in the same cycle.
REQ-025 The controller SHALL never drive a direct GREEN->RED transition on any slice without an intervening YELLOW.
REQ-026 A direction whose bit is dropped while it waits SHALL simply not be selected at the next latch point.

Reset
REQ-027 While rst=1, and immediately on its assertion (including mid-YELLOW or mid-ALL_RED), the block SHALL force phase=GREEN, cur_dir=0, next_dir=0 and cnt=0.
REQ-028 While rst=1, light SHALL show direction 0 GREEN and all other directions RED.
REQ-029 After rst deasserts, operation SHALL begin at the first rising edge with cnt=0.

Verification (defaults: NDIR=4, MIN=2, MAX=8, Y=1, AR=1)
REQ-030 Bench: release reset with car=0001 held -> dir0 GREEN for >= 20 cycles, phase=00 throughout.
REQ-031 Bench: car=0010 from reset release -> dir0 GREEN 2 cycles, YELLOW 1 cycle, all RED 1 cycle, then dir1 GREEN (light=...001_100 pattern), cur_dir=1.
REQ-032 Bench: cur_dir=0 with car=1011 held -> dir0 GREEN exactly 8 cycles (timeout), then yellow and all-red, then dir1 GREEN; after dir1's 8 cycles, dir3 GREEN; after dir3's 8 cycles, dir0 GREEN (round-robin skips dir2).
REQ-033 Bench: car=0100 pulsed at the GREEN->YELLOW edge, then car=1000 -> dir2 still receives green; dir3 is served afterward.
REQ-034 Bench: assert rst during ALL_RED -> same cycle shows light dir0=001, others=100, phase=00, cur_dir=0.
REQ-035 Bench: sweep NDIR=2, ALLRED_CYC=0, YELLOW_CYC=3 with car alternating -> yellow lasts 3 cycles, no ALL_RED, and the one-hot/single-non-red assertions hold every cycle.
